// File: rtl/chnl_responder.sv
// Channel valid/ready write responder: buffers initiator words in a show-ahead FIFO for the arbiter.
// Optional sticky protocol-error flag enabled with `define CHNL_RESP_ERR_CHK_EN.
module chnl_responder #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned MW    = 6
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [DW-1:0] ch_data,
  input  logic          ch_valid,
  output logic          ch_ready,
  output logic [MW-1:0] ch_margin,
  output logic          req_o,
  output logic [DW-1:0] data_o,
  input  logic          pop_i,
  output logic          err_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [MW-1:0] count;
  logic          wr_en;
  logic          rd_en;
  logic          not_empty;

  // Flow control decoded from registered count; no look-ahead at pop_i.
  assign not_empty = (count != '0);
  assign ch_ready  = (count < MW'(DEPTH));
  assign ch_margin = MW'(DEPTH) - count;
  assign req_o     = not_empty;
  assign data_o    = not_empty ? mem[rd_ptr] : '0;

  assign wr_en = ch_valid & ch_ready;
  assign rd_en = pop_i & not_empty;

  // Storage is not reset; data_o is gated by count instead.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= ch_data;
    end
  end

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + MW'(1);
        2'b01:   count <= count - MW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef CHNL_RESP_ERR_CHK_EN
  logic valid_q;
  logic ready_q;
  logic err_q;

  // Sticky on empty pop or on an initiator withdrawing a word it was refused.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      valid_q <= ch_valid;
      ready_q <= ch_ready;
      if ((pop_i && !not_empty) || (valid_q && !ready_q && !ch_valid)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_chnl_responder.sv
// Self-checking bench for chnl_responder: directed vector table plus hand-written FIFO sequences.
module tb_chnl_responder;

`ifdef CHNL_RESP_ERR_CHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int DEPTH = 32;

  logic        clk;
  logic        rstn;
  logic [31:0] ch_data;
  logic        ch_valid;
  logic        ch_ready;
  logic [5:0]  ch_margin;
  logic        req_o;
  logic [31:0] data_o;
  logic        pop_i;
  logic        err_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] q[$];
  logic        exp_err = 1'b0;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        p;
    logic        rdy;
    logic [5:0]  mg;
    logic        req;
    logic [31:0] dat;
    logic        err;
  } vec_t;

  vec_t tbl[8];

  chnl_responder dut (
    .clk       (clk),
    .rstn      (rstn),
    .ch_data   (ch_data),
    .ch_valid  (ch_valid),
    .ch_ready  (ch_ready),
    .ch_margin (ch_margin),
    .req_o     (req_o),
    .data_o    (data_o),
    .pop_i     (pop_i),
    .err_o     (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare all outputs against the queue model.
  task automatic check_state(input string nm);
    check({nm, ".ready"},  32'(ch_ready),  32'(q.size() < DEPTH));
    check({nm, ".margin"}, 32'(ch_margin), 32'(DEPTH - q.size()));
    check({nm, ".req"},    32'(req_o),     32'(q.size() > 0));
    check({nm, ".data"},   data_o,         (q.size() > 0) ? q[0] : 32'h0);
    check({nm, ".err"},    32'(err_o),     32'(exp_err));
  endtask

  // Drive one cycle, clock it, update the model, then compare.
  task automatic apply(input logic v, input logic [31:0] d, input logic p, input string nm);
    logic acc;
    logic pp;
    ch_valid = v;
    ch_data  = d;
    pop_i    = p;
    acc = v && (q.size() < DEPTH);
    pp  = p && (q.size() > 0);
    if (ERR_EN && p && q.size() == 0) exp_err = 1'b1;
    @(posedge clk);
    #1;
    if (pp) void'(q.pop_front());
    if (acc) q.push_back(d);
    check_state(nm);
  endtask

  initial begin
    tbl[0] = '{1'b1, 32'h0000_00A1, 1'b0, 1'b1, 6'd31, 1'b1, 32'h0000_00A1, 1'b0};
    tbl[1] = '{1'b1, 32'h0000_00A2, 1'b0, 1'b1, 6'd30, 1'b1, 32'h0000_00A1, 1'b0};
    tbl[2] = '{1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 6'd30, 1'b1, 32'h0000_00A1, 1'b0};
    tbl[3] = '{1'b1, 32'h0000_00A3, 1'b1, 1'b1, 6'd30, 1'b1, 32'h0000_00A2, 1'b0};
    tbl[4] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 6'd31, 1'b1, 32'h0000_00A3, 1'b0};
    tbl[5] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 6'd32, 1'b0, 32'h0000_0000, 1'b0};
    tbl[6] = '{1'b1, 32'h0000_00A4, 1'b1, 1'b1, 6'd31, 1'b1, 32'h0000_00A4, ERR_EN};
    tbl[7] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 6'd32, 1'b0, 32'h0000_0000, ERR_EN};

    rstn = 1'b1; ch_valid = 1'b0; ch_data = '0; pop_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_state("in_reset");
    rstn = 1'b0;
    apply(1'b0, 32'h0, 1'b0, "post_reset");

    // Vector table: basic writes, ignored data, write+pop, write+pop at empty.
    for (int i = 0; i < 8; i++) begin
      ch_valid = tbl[i].v;
      ch_data  = tbl[i].d;
      pop_i    = tbl[i].p;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d.ready", i),  32'(ch_ready),  32'(tbl[i].rdy));
      check($sformatf("vec%0d.margin", i), 32'(ch_margin), 32'(tbl[i].mg));
      check($sformatf("vec%0d.req", i),    32'(req_o),     32'(tbl[i].req));
      check($sformatf("vec%0d.data", i),   data_o,         tbl[i].dat);
      check($sformatf("vec%0d.err", i),    32'(err_o),     32'(tbl[i].err));
    end
    exp_err = ERR_EN;

    // Fill to full, then hold a refused word.
    for (int i = 0; i < 32; i++) apply(1'b1, 32'h00C0_0000 + 32'(i), 1'b0, "fill");
    for (int i = 0; i < 5; i++) apply(1'b1, 32'h00C0_0020, 1'b0, "full_hold");
    exp_err = ERR_EN;
    apply(1'b0, 32'h0, 1'b0, "withdraw");

    // Drain in order, then the held word goes in.
    for (int i = 0; i < 32; i++) apply(1'b0, 32'h0, 1'b1, "drain");
    apply(1'b1, 32'h00C0_0020, 1'b0, "late_word");
    apply(1'b0, 32'h0, 1'b1, "late_pop");

    // Full plus valid+pop: only the pop happens.
    for (int i = 0; i < 32; i++) apply(1'b1, 32'h00D0_0000 + 32'(i), 1'b0, "fill2");
    apply(1'b1, 32'h00D0_00FF, 1'b1, "full_wr_pop");
    check("full_wr_pop.margin1", 32'(ch_margin), 32'd1);
    for (int i = 0; i < 31; i++) apply(1'b0, 32'h0, 1'b1, "drain2");

    // Steady state at count 5 across pointer wrap.
    for (int i = 0; i < 5; i++) apply(1'b1, 32'h00E0_0000 + 32'(i), 1'b0, "pre5");
    for (int i = 0; i < 20; i++) begin
      apply(1'b1, 32'h00E0_0100 + 32'(i), 1'b1, "wr_pop5");
      check("wr_pop5.margin27", 32'(ch_margin), 32'd27);
    end
    for (int i = 0; i < 5; i++) apply(1'b0, 32'h0, 1'b1, "drain5");

    // Empty pops are ignored.
    for (int i = 0; i < 3; i++) apply(1'b0, 32'h0, 1'b1, "empty_pop");
    apply(1'b1, 32'h00F0_0001, 1'b0, "after_empty_wr");
    apply(1'b0, 32'h0, 1'b1, "after_empty_pop");

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 12; i++) apply(1'b1, 32'h0012_0000 + 32'(i), 1'b0, "pre_rst");
    ch_valid = 1'b0;
    rstn = 1'b1;
    #1;
    q.delete();
    exp_err = 1'b0;
    check_state("mid_reset");
    @(posedge clk);
    #1;
    rstn = 1'b0;
    for (int i = 0; i < 4; i++) apply(1'b1, 32'h0013_0000 + 32'(i), 1'b0, "post_rst_wr");
    for (int i = 0; i < 4; i++) apply(1'b0, 32'h0, 1'b1, "post_rst_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chnl_responder.md
Name: chnl_responder

Overview:
- Receiving end of the channel valid/ready write protocol.
- Accepts 32-bit words from one channel initiator into a show-ahead FIFO.
- Reports backpressure through ready and free space through margin.
- Presents buffered words to a downstream arbiter as a request plus a pop strobe.
- One instance per channel in front of the multi-channel arbiter.

Parameters:
- DW, 32: data width.
- DEPTH, 32: FIFO entries; power of two, at least 2.
- MW, 6: margin width; equals $clog2(DEPTH)+1.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rstn  input  1  reset; asynchronous, active-high.
- ch_data  input  DW  write data from initiator.
- ch_valid  input  1  initiator write request.
- ch_ready  output  MW?—no: 1  responder can accept a word this cycle.
- ch_margin  output  MW  free entries, DEPTH minus count.
- req_o  output  1  FIFO non-empty; request to arbiter.
- data_o  output  DW  head-of-FIFO word (show-ahead).
- pop_i  input  1  arbiter grant; consume head word this cycle.
- err_o  output  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset (rstn=1, asynchronous): rd/wr pointers and count = 0.
  - Outputs during reset: ch_ready=1, ch_margin=DEPTH (32), req_o=0, data_o=0, err_o=0.
  - Asserting reset mid-operation discards all contents immediately, without waiting for a clock edge.
- Storage: DEPTH x DW array; write pointer and read pointer each log2(DEPTH) bits; count is MW bits, range 0..DEPTH.
- Pointers wrap modulo DEPTH with no gap: DEPTH-1 -> 0.
- ch_ready = (count < DEPTH), decoded combinationally from registered count.
  - ch_ready does not look ahead at pop_i: when full, a same-cycle pop does not enable a write.
- Write: a word is accepted on a rising edge where ch_valid=1 and ch_ready=1; it is stored at wr_ptr and wr_ptr increments.
  - If ch_valid=1 and ch_ready=0, nothing is stored. The initiator holds data; no state changes.
  - ch_data is ignored when ch_valid=0.
- Read: on a rising edge where pop_i=1 and count>0, rd_ptr increments.
  - pop_i with count=0 is ignored: pointers and count unchanged.
- data_o = mem[rd_ptr] when count>0, else 0. req_o = (count>0).
- Latency:
  - A word accepted at edge N is visible on data_o and raises req_o after edge N, i.e. the next cycle.
  - ch_margin and ch_ready reflect edge N in that same cycle.
- Count update per edge:
  - write only: +1.
  - pop only (non-empty): -1.
  - write and pop together (0 < count < DEPTH): unchanged, both pointers advance.
  - write and pop together at count=0: write only, since the pop is ignored.
- ch_margin = DEPTH - count. It is 0 exactly when ch_ready=0.
- Data order is strict FIFO; no reordering, no duplication, no loss of any accepted word.

Optional Feature:
- Macro: CHNL_RESP_ERR_CHK_EN.
- Defined:
  - err_o is a sticky flag. It is set on the edge where pop_i=1 with count=0 (underflow).
  - It is also set on the edge where ch_valid falls 1->0 while ch_ready was 0 in the previous cycle (initiator withdrew an unaccepted word).
  - Cleared only by reset.
  - Requires one registered copy of ch_valid and ch_ready.
- Undefined: err_o tied to 0; no extra flops.

Test Plan:
- Reset release: hold rstn=1 for 10 cycles, then 0 -> ch_ready=1, ch_margin=32, req_o=0, data_o=0, err_o=0.
- Fill to full: write 0x00C0_0000..0x00C0_001F back-to-back with pop_i=0.
  - After the 32nd edge: ch_ready=0, ch_margin=0, req_o=1.
  - A 33rd word 0x00C0_0020 held valid for 5 cycles is not accepted and margin stays 0.
- Drain order: from full, assert pop_i=1 for 32 cycles.
  - data_o sequence is 0x00C0_0000..0x00C0_001F.
  - ch_margin rises 1..32; req_o=0 after the last pop.
  - Then release the held 0x00C0_0020 -> accepted the cycle ch_ready returns.
- Simultaneous write/pop:
  - With count=5, 20 cycles of valid+pop -> count stays 5, margin 27, data_o order preserved across pointer wrap.
  - At count=32 with valid+pop -> only the pop occurs, count 31.
- Empty pop: count=0, pop_i=1 for 3 cycles -> pointers unchanged, req_o=0. err_o=1 if CHNL_RESP_ERR_CHK_EN is defined, else 0.
- Reset mid-stream: count=12, assert rstn between edges -> ch_margin=32, req_o=0 before the next edge; later writes start at entry 0 in correct order.
